uart_rx_variable_rate: RTL and testbench

Parametrised UART receiver with a divisor that can be changed at runtime. It detects the start bit, samples each bit at mid-bit, checks the stop bit and presents each received word with a one-cycle valid pulse. It replaces fixed-rate, button-triggered bit capture: framing is detected from the line itself. Its output feeds the seven-segment/byte display path and downstream byte consumers.

---
 rtl/uart_rx_variable_rate.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_variable_rate.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_variable_rate.sv
// uart_rx_variable_rate
//   UART receiver with a divisor that can be reloaded at runtime. The line is
//   synchronised, the start bit is confirmed at mid-bit, each data bit is
//   sampled one bit period after the previous sample, and the stop bit is
//   checked before the word is published.
//
// Ports
//   i_Clk           system clock
//   i_Rst           asynchronous active-high reset
//   i_Rx_Serial     serial line, idle high, asynchronous to i_Clk
//   i_Clks_Per_Bit  requested divisor (clocks per bit)
//   i_Rate_Load     one-cycle strobe; latches i_Clks_Per_Bit when idle
//   o_Rx_DV         one-cycle pulse, o_Rx_Byte holds a new good word
//   o_Rx_Byte       last good word, held until the next good frame
//   o_Framing_Err   one-cycle pulse when the stop bit is sampled low
//   o_Busy          high whenever the receiver is not idle
//   o_Clks_Per_Bit  active divisor N
//
// Output handshake: o_Rx_DV is a valid-only strobe with no ready; a consumer
// must capture o_Rx_Byte in the cycle o_Rx_DV is high (the byte itself stays
// stable until the next good frame). o_Rx_DV and o_Framing_Err never assert
// together and each fires at most once per frame.
//
// The FSM state is kept in the signal 'state' (type state_t) so that checkers
// can bind to it directly.

module uart_rx_variable_rate #(
   parameter int DATA_BITS            = 8,
   parameter int DIV_WIDTH            = 16,
   parameter int DEFAULT_CLKS_PER_BIT = 217,
   parameter int MSB_FIRST            = 0,
   parameter int SYNC_STAGES          = 2
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst,
   input  logic                 i_Rx_Serial,
   input  logic [DIV_WIDTH-1:0] i_Clks_Per_Bit,
   input  logic                 i_Rate_Load,
   output logic                 o_Rx_DV,
   output logic [DATA_BITS-1:0] o_Rx_Byte,
   output logic                 o_Framing_Err,
   output logic                 o_Busy,
   output logic [DIV_WIDTH-1:0] o_Clks_Per_Bit
);

   localparam int IDX_W = $clog2(DATA_BITS + 1);
   localparam logic [DIV_WIDTH-1:0] MIN_DIV     = DIV_WIDTH'(4);
   localparam logic [DIV_WIDTH-1:0] RESET_DIV   = DIV_WIDTH'(DEFAULT_CLKS_PER_BIT);
   localparam logic [IDX_W-1:0]     LAST_BIT_IX = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      DATA       = 3'd2,
      STOP       = 3'd3,
      BREAK_WAIT = 3'd4
   } state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_Rx;
   logic [DIV_WIDTH-1:0]   clks_per_bit;
   logic [DIV_WIDTH-1:0]   half_bit;
   logic [DIV_WIDTH-1:0]   last_cnt;
   logic [DIV_WIDTH-1:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0]       bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0]   shift_q, shift_nxt;
   logic [DATA_BITS-1:0]   rx_byte;
   logic                   rx_dv, rx_dv_nxt;
   logic                   framing_err, framing_err_nxt;
   logic                   load_byte;
   logic                   rate_load_ok;
   logic [DIV_WIDTH-1:0]   rate_req;

   // ---------------------------------------------------------------------
   // Input synchroniser; resets to idle-high so no false start after reset
   // ---------------------------------------------------------------------
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_Rx_Serial};
      end
   end

   assign s_Rx = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------------
   // Divisor register. A load is only taken in IDLE when the line is still
   // high, so a frame never sees N change under it; the floor of 4 keeps
   // the mid-bit point H distinct from both 0 and N-1.
   // ---------------------------------------------------------------------
   assign rate_load_ok = i_Rate_Load && (state == IDLE) && s_Rx;
   assign rate_req     = (i_Clks_Per_Bit < MIN_DIV) ? MIN_DIV : i_Clks_Per_Bit;
   assign half_bit     = (clks_per_bit - DIV_WIDTH'(1)) >> 1;
   assign last_cnt     = clks_per_bit - DIV_WIDTH'(1);

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         clks_per_bit <= RESET_DIV;
      end else if (rate_load_ok) begin
         clks_per_bit <= rate_req;
      end
   end

   // ---------------------------------------------------------------------
   // FSM state register and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift_q     <= '0;
         rx_byte     <= '0;
         rx_dv       <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         bit_idx     <= bit_idx_nxt;
         shift_q     <= shift_nxt;
         rx_dv       <= rx_dv_nxt;
         framing_err <= framing_err_nxt;
         if (load_byte) begin
            rx_byte <= shift_q;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and datapath control
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      bit_idx_nxt     = bit_idx;
      shift_nxt       = shift_q;
      rx_dv_nxt       = 1'b0;
      framing_err_nxt = 1'b0;
      load_byte       = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!s_Rx) begin
               state_nxt = START;
            end
         end

         // Confirm the start bit at mid-bit; a high line here was a glitch.
         START: begin
            if (cnt == half_bit) begin
               cnt_nxt     = '0;
               bit_idx_nxt = '0;
               state_nxt   = s_Rx ? IDLE : DATA;
            end else begin
               cnt_nxt = cnt + DIV_WIDTH'(1);
            end
         end

         // Counting a full N from the mid-start sample lands every data
         // sample in the middle of its bit.
         DATA: begin
            if (cnt == last_cnt) begin
               cnt_nxt     = '0;
               bit_idx_nxt = bit_idx + IDX_W'(1);
               if (MSB_FIRST != 0) begin
                  shift_nxt = {shift_q[DATA_BITS-2:0], s_Rx};
               end else begin
                  shift_nxt = {s_Rx, shift_q[DATA_BITS-1:1]};
               end
               if (bit_idx == LAST_BIT_IX) begin
                  state_nxt = STOP;
               end
            end else begin
               cnt_nxt = cnt + DIV_WIDTH'(1);
            end
         end

         // Stop sample is taken mid stop bit, leaving half a bit of margin
         // before a back-to-back start edge can arrive.
         STOP: begin
            if (cnt == last_cnt) begin
               cnt_nxt = '0;
               if (s_Rx) begin
                  load_byte = 1'b1;
                  rx_dv_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  framing_err_nxt = 1'b1;
                  state_nxt       = BREAK_WAIT;
               end
            end else begin
               cnt_nxt = cnt + DIV_WIDTH'(1);
            end
         end

         // A line held low after a bad stop bit is a break, not a new start.
         BREAK_WAIT: begin
            cnt_nxt = '0;
            if (s_Rx) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign o_Rx_DV        = rx_dv;
   assign o_Rx_Byte      = rx_byte;
   assign o_Framing_Err  = framing_err;
   assign o_Busy         = (state != IDLE);
   assign o_Clks_Per_Bit = clks_per_bit;

endmodule

// File: tb/tb_uart_rx_variable_rate.sv
// Testbench for uart_rx_variable_rate. Two receivers share one serial line:
// one LSB-first, one MSB-first, so every frame checks both bit orders.
// Stimulus pushes the expected event {is_framing_err, byte} into a queue per
// receiver; monitors pop and compare whenever a receiver pulses an output.

module tb_uart_rx_variable_rate;

   localparam int W = 9;

   logic        i_Clk = 1'b0;
   logic        i_Rst = 1'b0;
   logic        i_Rx_Serial = 1'b1;
   logic [15:0] i_Clks_Per_Bit = 16'd217;
   logic        i_Rate_Load = 1'b0;

   logic        l_dv, l_err, l_busy;
   logic [7:0]  l_byte;
   logic [15:0] l_n;
   logic        m_dv, m_err, m_busy;
   logic [7:0]  m_byte;
   logic [15:0] m_n;

   int checks = 0;
   int errors = 0;
   int l_dv_cnt = 0;
   int m_dv_cnt = 0;

   logic [W-1:0] exp_l_q[$];
   logic [W-1:0] exp_m_q[$];
   logic [7:0]   last_l = 8'h00;
   logic [7:0]   last_m = 8'h00;

   uart_rx_variable_rate #(.MSB_FIRST(0)) dut_l (
      .i_Clk          (i_Clk),
      .i_Rst          (i_Rst),
      .i_Rx_Serial    (i_Rx_Serial),
      .i_Clks_Per_Bit (i_Clks_Per_Bit),
      .i_Rate_Load    (i_Rate_Load),
      .o_Rx_DV        (l_dv),
      .o_Rx_Byte      (l_byte),
      .o_Framing_Err  (l_err),
      .o_Busy         (l_busy),
      .o_Clks_Per_Bit (l_n)
   );

   uart_rx_variable_rate #(.MSB_FIRST(1)) dut_m (
      .i_Clk          (i_Clk),
      .i_Rst          (i_Rst),
      .i_Rx_Serial    (i_Rx_Serial),
      .i_Clks_Per_Bit (i_Clks_Per_Bit),
      .i_Rate_Load    (i_Rate_Load),
      .o_Rx_DV        (m_dv),
      .o_Rx_Byte      (m_byte),
      .o_Framing_Err  (m_err),
      .o_Busy         (m_busy),
      .o_Clks_Per_Bit (m_n)
   );

   // ---------------- clock ----------------
   always #5 i_Clk = ~i_Clk;

   // ---------------- helpers ----------------
   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge i_Clk);
   endtask

   task automatic drive_bit(input logic b, input int n);
      i_Rx_Serial = b;
      repeat (n) @(negedge i_Clk);
   endtask

   // Wire order is data[0] first; the MSB-first receiver therefore expects
   // the bit-reversed word.
   task automatic send_frame(input logic [7:0] data, input logic stop, input int n);
      if (stop) begin
         exp_l_q.push_back({1'b0, data});
         exp_m_q.push_back({1'b0, rev8(data)});
         last_l = data;
         last_m = rev8(data);
      end else begin
         exp_l_q.push_back({1'b1, last_l});
         exp_m_q.push_back({1'b1, last_m});
      end
      drive_bit(1'b0, n);
      for (int i = 0; i < 8; i++) drive_bit(data[i], n);
      drive_bit(stop, n);
   endtask

   task automatic pulse_rate(input logic [15:0] v);
      i_Clks_Per_Bit = v;
      i_Rate_Load    = 1'b1;
      @(negedge i_Clk);
      i_Rate_Load    = 1'b0;
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_lsb_q_empty"}, exp_l_q.size(), 0);
      check({tag, "_msb_q_empty"}, exp_m_q.size(), 0);
   endtask

   // ---------------- scoreboard monitors ----------------
   always @(negedge i_Clk) begin
      logic [W-1:0] e;
      if (l_dv || l_err) begin
         if (l_dv) l_dv_cnt++;
         check("lsb_dv_err_exclusive", {31'b0, l_dv & l_err}, 0);
         if (exp_l_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL lsb_unexpected_event actual=%0h required=none", {l_err, l_byte});
         end else begin
            e = exp_l_q.pop_front();
            check("lsb_event", {23'b0, l_err, l_byte}, {23'b0, e});
         end
      end
   end

   always @(negedge i_Clk) begin
      logic [W-1:0] e;
      if (m_dv || m_err) begin
         if (m_dv) m_dv_cnt++;
         check("msb_dv_err_exclusive", {31'b0, m_dv & m_err}, 0);
         if (exp_m_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL msb_unexpected_event actual=%0h required=none", {m_err, m_byte});
         end else begin
            e = exp_m_q.pop_front();
            check("msb_event", {23'b0, m_err, m_byte}, {23'b0, e});
         end
      end
   end

   // ---------------- directed sequence ----------------
   initial begin
      int k;
      int l_prev;

      // reset
      #2 i_Rst = 1'b1;
      repeat (3) @(negedge i_Clk);
      check("rst_dv",   l_dv,   0);
      check("rst_byte", l_byte, 0);
      check("rst_err",  l_err,  0);
      check("rst_busy", l_busy, 0);
      check("rst_n",    l_n,    217);
      i_Rst = 1'b0;
      idle(5);

      // 1: 0xA5 at 217 clk/bit
      send_frame(8'hA5, 1'b1, 217);
      idle(20);
      check("t1_dv_count_lsb", l_dv_cnt, 1);
      check("t1_dv_count_msb", m_dv_cnt, 1);
      check("t1_byte", l_byte, 8'hA5);
      check("t1_n", l_n, 217);
      check_drained("t1");

      // 2: runtime divisor; a load during a frame is ignored
      pulse_rate(16'd16);
      idle(1);
      check("t2_n_loaded", l_n, 16);
      fork
         send_frame(8'h3C, 1'b1, 16);
         begin
            idle(40);
            pulse_rate(16'd40);
            check("t2_busy_mid", l_busy, 1);
            check("t2_n_mid", l_n, 16);
         end
      join
      idle(10);
      check("t2_n_after", l_n, 16);
      check("t2_byte", l_byte, 8'h3C);
      check_drained("t2");
      pulse_rate(16'd2);
      idle(1);
      check("t2_n_floor", l_n, 4);
      check("t2_n_floor_msb", m_n, 4);
      pulse_rate(16'd16);
      idle(1);
      check("t2_n_back16", l_n, 16);

      // 3: 5-cycle glitch at N=16. Busy must drop once the mid-start sample
      // sees the line high again; the bound allows for the synchroniser.
      l_prev = l_dv_cnt;
      i_Rx_Serial = 1'b0;
      idle(5);
      check("t3_busy_in_glitch", l_busy, 1);
      i_Rx_Serial = 1'b1;
      k = 5;
      while (l_busy && k < 12) begin
         @(negedge i_Clk);
         k++;
      end
      check("t3_busy_fell", l_busy, 0);
      check("t3_no_dv", l_dv_cnt, l_prev);
      idle(10);
      send_frame(8'h81, 1'b1, 16);
      idle(10);
      check("t3_byte", l_byte, 8'h81);
      check_drained("t3");

      // 4: bad stop bit followed by a 200-cycle break
      send_frame(8'h55, 1'b0, 16);
      l_prev = l_dv_cnt;
      idle(200);
      check("t4_busy_in_break", l_busy, 1);
      check("t4_byte_held", l_byte, 8'h81);
      check("t4_no_dv_in_break", l_dv_cnt, l_prev);
      i_Rx_Serial = 1'b1;
      idle(10);
      check("t4_idle_after_break", l_busy, 0);
      send_frame(8'h12, 1'b1, 16);
      idle(10);
      check("t4_byte", l_byte, 8'h12);
      check_drained("t4");

      // 5: bit order and back-to-back frames
      send_frame(8'h01, 1'b1, 16);
      idle(10);
      check("t5_lsb_first", l_byte, 8'h01);
      check("t5_msb_first", m_byte, 8'h80);
      l_prev = l_dv_cnt;
      send_frame(8'hF0, 1'b1, 16);
      send_frame(8'h0F, 1'b1, 16);
      idle(20);
      check("t5_b2b_dv_count", l_dv_cnt, l_prev + 2);
      check("t5_b2b_byte", l_byte, 8'h0F);
      check("t5_b2b_byte_msb", m_byte, 8'hF0);
      check_drained("t5");

      // 6: asynchronous reset in the middle of bit 4; nothing is pushed for
      // the aborted frame
      drive_bit(1'b0, 16);
      for (int i = 0; i < 4; i++) drive_bit(i[0], 16);
      drive_bit(1'b1, 8);
      #2 i_Rst = 1'b1;
      #1;
      check("t6_rst_dv",   l_dv,   0);
      check("t6_rst_byte", l_byte, 0);
      check("t6_rst_byte_msb", m_byte, 0);
      check("t6_rst_err",  l_err,  0);
      check("t6_rst_busy", l_busy, 0);
      check("t6_rst_n",    l_n,    217);
      i_Rx_Serial = 1'b1;
      last_l = 8'h00;
      last_m = 8'h00;
      idle(3);
      i_Rst = 1'b0;
      idle(5);
      send_frame(8'h7E, 1'b1, 217);
      idle(20);
      check("t6_byte", l_byte, 8'h7E);
      check("t6_byte_msb", m_byte, 8'h7E);

      // drain, bounded
      k = 0;
      while ((exp_l_q.size() != 0 || exp_m_q.size() != 0) && k < 1000) begin
         @(negedge i_Clk);
         k++;
      end
      check_drained("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
